// File: rtl/priority_encoder16to4_pkg.sv
// enc_pkg: constants and FSM state type shared by the priority encoder
// slice (top, handshake interface, 8-to-3 sub-encoder).
//   N_REQ       number of request lines (fixed at 16)
//   IDX_W       index width, log2(N_REQ)
//   enc_state_t IDLE / PRESENT handshake states
package enc_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

endpackage

// File: rtl/priority_encoder16to4_if.sv
// priority_encoder16to4_if: request/handshake bundle for the priority encoder.
//   enable  capture enable              (master -> slave)
//   req     request lines               (master -> slave)
//   mask    selection exclusion mask    (master -> slave)
//   ack     consumer accepts idx        (master -> slave)
//   clr_ovf clears the overrun flag     (master -> slave)
//   idx     presented index             (slave -> master)
//   valid   idx is meaningful           (slave -> master)
//   pending current pending register    (slave -> master)
//   ovf     sticky overrun flag         (slave -> master)
interface priority_encoder16to4_if;
  import enc_pkg::*;

  logic             enable;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] mask;
  logic             ack;
  logic             clr_ovf;
  logic [IDX_W-1:0] idx;
  logic             valid;
  logic [N_REQ-1:0] pending;
  logic             ovf;

  modport master (
    output enable, req, mask, ack, clr_ovf,
    input  idx, valid, pending, ovf
  );

  modport slave (
    input  enable, req, mask, ack, clr_ovf,
    output idx, valid, pending, ovf
  );

endinterface

// File: rtl/priority_encoder16to4_enc8.sv
// priority_encoder8to3: combinational 8-to-3 priority encoder.
//   in   input lines, bit 7 is highest priority
//   idx  index of the highest set bit (0 when nothing is set)
//   any  at least one input bit is set
module priority_encoder8to3 (
  input  logic [7:0] in,
  output logic [2:0] idx,
  output logic       any
);

  // Ascending scan: the last hit, i.e. the highest set bit, wins.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) idx = 3'(i);
    end
  end

  assign any = |in;

endmodule

// File: rtl/priority_encoder16to4.sv
// priority_encoder16to4: registered 16-to-4 priority encoder with sticky
// request capture and a valid/ack handshake.
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of priority_encoder16to4_if
//            in:  enable, req, mask, ack, clr_ovf
//            out: idx, valid, pending, ovf (all direct register outputs)
module priority_encoder16to4
  import enc_pkg::*;
(
  input logic                     clk,
  input logic                     rst_n,
  priority_encoder16to4_if.slave  bus
);

  enc_state_t       state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             valid_reg, valid_next;
  logic [N_REQ-1:0] pending_reg, pending_next;
  logic             ovf_reg, ovf_next;

  logic [N_REQ-1:0] clear_vec;
  logic [N_REQ-1:0] req_cap;
  logic [N_REQ-1:0] sel;
  logic [2:0]       hi_idx, lo_idx;
  logic             hi_any, lo_any;
  logic [IDX_W-1:0] winner;

  // The presented line is dropped only on a real acknowledge.
  assign clear_vec = (bus.ack && valid_reg) ? ({{(N_REQ-1){1'b0}}, 1'b1} << idx_reg)
                                            : '0;
  assign req_cap   = bus.enable ? bus.req : '0;

  // OR-ing the new requests after the clear makes a same-cycle re-request win.
  assign pending_next = (pending_reg & ~clear_vec) | req_cap;

  // A request that hits a still-pending line (not being cleared now) is lost.
  // Set takes precedence over clr_ovf.
  assign ovf_next = (|(req_cap & pending_reg & ~clear_vec)) ? 1'b1 :
                    bus.clr_ovf                             ? 1'b0 : ovf_reg;

  assign sel = pending_reg & ~bus.mask;

  priority_encoder8to3 u_hi (
    .in  (sel[15:8]),
    .idx (hi_idx),
    .any (hi_any)
  );

  priority_encoder8to3 u_lo (
    .in  (sel[7:0]),
    .idx (lo_idx),
    .any (lo_any)
  );

  assign winner = {hi_any, hi_any ? hi_idx : lo_idx};

  // Once PRESENT, idx is frozen: no preemption and mask changes are ignored.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (hi_any || lo_any) begin
          idx_next   = winner;
          valid_next = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ack) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      valid_reg   <= 1'b0;
      pending_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      valid_reg   <= valid_next;
      pending_reg <= pending_next;
      ovf_reg     <= ovf_next;
    end
  end

  assign bus.idx     = idx_reg;
  assign bus.valid   = valid_reg;
  assign bus.pending = pending_reg;
  assign bus.ovf     = ovf_reg;

endmodule
